// File: rtl/interrupt_acceptor.sv
// CPU-side interrupt acceptor: samples intr/irq at instruction boundaries, issues a
// one-cycle inta, and presents the vector to the core with NMI taking priority.
module interrupt_acceptor #(
  parameter logic [7:0]  NMI_VECTOR = 8'h02,
  parameter int unsigned MIN_GAP    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       intr,
  input  logic [7:0] irq,
  output logic       inta,
  input  logic       nmi,
  input  logic       int_enabled,
  input  logic       inst_boundary,
  output logic       int_start,
  output logic [7:0] int_vector,
  output logic       int_nmi,
  input  logic       int_taken
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INTA,
    ST_PRESENT,
    ST_GAP
  } state_e;

  localparam logic [3:0] GAP_LOAD = 4'(MIN_GAP - 1);

  state_e     state_q;
  logic       nmi_last_q;
  logic       nmi_pending_q;
  logic       inta_q;
  logic       int_start_q;
  logic       int_nmi_q;
  logic [7:0] int_vector_q;
  logic [3:0] gap_cnt_q;

  logic nmi_edge;
  assign nmi_edge = nmi & ~nmi_last_q;

  // NOTE: all state here uses non-blocking assignments so every register samples
  // the pre-edge values; later assignments in the block override earlier defaults.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      nmi_last_q    <= 1'b0;
      nmi_pending_q <= 1'b0;
      inta_q        <= 1'b0;
      int_start_q   <= 1'b0;
      int_nmi_q     <= 1'b0;
      int_vector_q  <= 8'h00;
      gap_cnt_q     <= 4'd0;
    end else begin
      nmi_last_q <= nmi;
      // Repeated edges simply keep the single pending flag set.
      if (nmi_edge) nmi_pending_q <= 1'b1;

      unique case (state_q)
        ST_IDLE: begin
          if (inst_boundary) begin
            if (nmi_pending_q) begin
              int_vector_q  <= NMI_VECTOR;
              int_nmi_q     <= 1'b1;
              int_start_q   <= 1'b1;
              // An edge arriving as the pending NMI is consumed queues another one.
              nmi_pending_q <= nmi_edge;
              state_q       <= ST_PRESENT;
            end else if (intr && int_enabled) begin
              int_vector_q <= irq;
              int_nmi_q    <= 1'b0;
              inta_q       <= 1'b1;
              state_q      <= ST_INTA;
            end
          end
        end

        // irq is deliberately not sampled here: the controller drives 0 during inta.
        ST_INTA: begin
          inta_q      <= 1'b0;
          int_start_q <= 1'b1;
          state_q     <= ST_PRESENT;
        end

        ST_PRESENT: begin
          if (int_taken) begin
            int_start_q <= 1'b0;
            gap_cnt_q   <= GAP_LOAD;
            state_q     <= ST_GAP;
          end
        end

        // Gives the controller's in-service update time to reach intr.
        ST_GAP: begin
          if (gap_cnt_q == 4'd0) begin
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign inta       = inta_q;
  assign int_start  = int_start_q;
  assign int_vector = int_vector_q;
  assign int_nmi    = int_nmi_q;

endmodule

// File: tb/tb_interrupt_acceptor.sv
// Scenario bench for interrupt_acceptor: expected presentations are queued when
// stimulus is driven and compared when int_start rises.
module tb_interrupt_acceptor;

  localparam logic [7:0] NMI_VEC = 8'h02;
  localparam int         GAP     = 2;

  typedef struct packed {
    logic [7:0] vector;
    logic       nmi;
  } pres_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       intr = 1'b0;
  logic [7:0] irq = 8'h00;
  logic       inta;
  logic       nmi = 1'b0;
  logic       int_enabled = 1'b0;
  logic       inst_boundary = 1'b0;
  logic       int_start;
  logic [7:0] int_vector;
  logic       int_nmi;
  logic       int_taken = 1'b0;

  int    n_total = 0;
  int    n_pass  = 0;
  pres_t sb_q[$];

  int inta_cnt    = 0;
  bit inta_prev   = 1'b0;
  bit inta_consec = 1'b0;

  interrupt_acceptor #(.NMI_VECTOR(NMI_VEC), .MIN_GAP(GAP)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .intr         (intr),
    .irq          (irq),
    .inta         (inta),
    .nmi          (nmi),
    .int_enabled  (int_enabled),
    .inst_boundary(inst_boundary),
    .int_start    (int_start),
    .int_vector   (int_vector),
    .int_nmi      (int_nmi),
    .int_taken    (int_taken)
  );

  always #5 clk = ~clk;

  // inta pulse monitor, sampled 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    if (inta === 1'b1) inta_cnt++;
    if (inta === 1'b1 && inta_prev) inta_consec = 1'b1;
    inta_prev = (inta === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pop_expected(output pres_t e);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else e = 'x;
  endtask

  task automatic wait_for_inta(input int budget, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = budget;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (inta === 1'b1) begin
        ok = 1'b1;
        cycles = i + 1;
        break;
      end
    end
  endtask

  task automatic wait_for_start(input int budget, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = budget;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int_start === 1'b1) begin
        ok = 1'b1;
        cycles = i + 1;
        break;
      end
    end
  endtask

  task automatic take_and_settle();
    int_taken = 1'b1;
    @(negedge clk);
    int_taken = 1'b0;
    repeat (GAP + 1) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (inta !== 1'b0) $display("FAIL reset_inta: got %b want 0", inta); else n_pass++;
    n_total++; if (int_start !== 1'b0) $display("FAIL reset_start: got %b want 0", int_start); else n_pass++;
    n_total++; if (int_vector !== 8'h00) $display("FAIL reset_vector: got %h want 00", int_vector); else n_pass++;
    n_total++; if (int_nmi !== 1'b0) $display("FAIL reset_nmi: got %b want 0", int_nmi); else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_maskable();
    pres_t e;
    bit ok;
    int cyc;
    intr = 1'b1; irq = 8'h0C; int_enabled = 1'b1; inst_boundary = 1'b1;
    sb_q.push_back('{vector: 8'h0C, nmi: 1'b0});
    @(negedge clk);
    n_total++; if (inta !== 1'b1) $display("FAIL basic_inta_high: got %b want 1", inta); else n_pass++;
    n_total++; if (int_start !== 1'b0) $display("FAIL basic_start_early: got %b want 0", int_start); else n_pass++;
    intr = 1'b0; irq = 8'h00;
    @(negedge clk);
    n_total++; if (inta !== 1'b0) $display("FAIL basic_inta_drop: got %b want 0", inta); else n_pass++;
    n_total++; if (int_start !== 1'b1) $display("FAIL basic_start: got %b want 1", int_start); else n_pass++;
    pop_expected(e);
    n_total++; if (int_vector !== e.vector) $display("FAIL basic_vector: got %h want %h", int_vector, e.vector); else n_pass++;
    n_total++; if (int_nmi !== e.nmi) $display("FAIL basic_nmi: got %b want %b", int_nmi, e.nmi); else n_pass++;
    int_taken = 1'b1;
    @(negedge clk);
    int_taken = 1'b0;
    n_total++; if (int_start !== 1'b0) $display("FAIL basic_start_clear: got %b want 0", int_start); else n_pass++;
    // Request immediately after the take: inta appears only once GAP has elapsed.
    intr = 1'b1; irq = 8'h21;
    sb_q.push_back('{vector: 8'h21, nmi: 1'b0});
    wait_for_inta(10, ok, cyc);
    n_total++; if (!ok || cyc != GAP + 1) $display("FAIL basic_gap_len: got ok=%0b cycles=%0d want cycles=%0d", ok, cyc, GAP + 1); else n_pass++;
    intr = 1'b0; irq = 8'h00;
    wait_for_start(4, ok, cyc);
    pop_expected(e);
    n_total++; if (!ok || int_vector !== e.vector) $display("FAIL basic_second_vector: got ok=%0b %h want %h", ok, int_vector, e.vector); else n_pass++;
    take_and_settle();
  endtask

  task automatic test_gating();
    pres_t e;
    bit ok;
    int cyc;
    int inta_before = inta_cnt;
    bit start_seen = 1'b0;
    intr = 1'b1; irq = 8'h33;
    for (int i = 0; i < 20; i++) begin
      int_enabled   = (i >= 10);
      inst_boundary = (i < 10);
      @(negedge clk);
      if (int_start !== 1'b0) start_seen = 1'b1;
    end
    n_total++; if (inta_cnt != inta_before) $display("FAIL gating_no_inta: got %0d pulses want 0", inta_cnt - inta_before); else n_pass++;
    n_total++; if (start_seen) $display("FAIL gating_no_start: got int_start=1 want 0"); else n_pass++;
    int_enabled = 1'b1; inst_boundary = 1'b1;
    sb_q.push_back('{vector: 8'h33, nmi: 1'b0});
    @(negedge clk);
    n_total++; if (inta !== 1'b1) $display("FAIL gating_accept: got inta=%b want 1", inta); else n_pass++;
    intr = 1'b0; irq = 8'h00;
    wait_for_start(4, ok, cyc);
    pop_expected(e);
    n_total++; if (!ok || int_vector !== e.vector || int_nmi !== e.nmi) $display("FAIL gating_vector: got ok=%0b %h/%b want %h/%b", ok, int_vector, int_nmi, e.vector, e.nmi); else n_pass++;
    take_and_settle();
  endtask

  task automatic test_nmi_priority();
    pres_t e;
    bit ok;
    int cyc;
    int inta_before = inta_cnt;
    inst_boundary = 1'b0; intr = 1'b1; irq = 8'h09; nmi = 1'b1;
    @(negedge clk);
    inst_boundary = 1'b1;
    sb_q.push_back('{vector: NMI_VEC, nmi: 1'b1});
    sb_q.push_back('{vector: 8'h09, nmi: 1'b0});
    @(negedge clk);
    n_total++; if (int_start !== 1'b1) $display("FAIL nmi_prio_start: got %b want 1", int_start); else n_pass++;
    pop_expected(e);
    n_total++; if (int_vector !== e.vector || int_nmi !== e.nmi) $display("FAIL nmi_prio_vector: got %h/%b want %h/%b", int_vector, int_nmi, e.vector, e.nmi); else n_pass++;
    n_total++; if (inta_cnt != inta_before) $display("FAIL nmi_prio_no_inta: got %0d pulses want 0", inta_cnt - inta_before); else n_pass++;
    nmi = 1'b0;
    int_taken = 1'b1;
    @(negedge clk);
    int_taken = 1'b0;
    wait_for_inta(10, ok, cyc);
    n_total++; if (!ok || cyc != GAP + 1) $display("FAIL nmi_prio_then_inta: got ok=%0b cycles=%0d want cycles=%0d", ok, cyc, GAP + 1); else n_pass++;
    intr = 1'b0; irq = 8'h00;
    wait_for_start(4, ok, cyc);
    pop_expected(e);
    n_total++; if (!ok || int_vector !== e.vector || int_nmi !== e.nmi) $display("FAIL nmi_prio_maskable: got ok=%0b %h/%b want %h/%b", ok, int_vector, int_nmi, e.vector, e.nmi); else n_pass++;
    take_and_settle();
  endtask

  task automatic test_nmi_during_present();
    pres_t e;
    bit ok;
    int cyc;
    bit extra_start = 1'b0;
    intr = 1'b1; irq = 8'h44;
    sb_q.push_back('{vector: 8'h44, nmi: 1'b0});
    wait_for_inta(3, ok, cyc);
    intr = 1'b0; irq = 8'h00;
    wait_for_start(4, ok, cyc);
    pop_expected(e);
    n_total++; if (!ok || int_vector !== e.vector) $display("FAIL nmi_present_first: got ok=%0b %h want %h", ok, int_vector, e.vector); else n_pass++;
    // Two edges while presenting: only one NMI is expected afterwards.
    repeat (2) begin
      nmi = 1'b1; @(negedge clk);
      nmi = 1'b0; @(negedge clk);
    end
    sb_q.push_back('{vector: NMI_VEC, nmi: 1'b1});
    n_total++; if (int_start !== 1'b1 || int_vector !== 8'h44) $display("FAIL nmi_present_hold: got %b/%h want 1/44", int_start, int_vector); else n_pass++;
    int_taken = 1'b1;
    @(negedge clk);
    int_taken = 1'b0;
    wait_for_start(10, ok, cyc);
    pop_expected(e);
    n_total++; if (!ok || cyc != GAP + 1) $display("FAIL nmi_present_gap: got ok=%0b cycles=%0d want %0d", ok, cyc, GAP + 1); else n_pass++;
    n_total++; if (int_vector !== e.vector || int_nmi !== e.nmi) $display("FAIL nmi_present_vector: got %h/%b want %h/%b", int_vector, int_nmi, e.vector, e.nmi); else n_pass++;
    take_and_settle();
    repeat (10) begin
      @(negedge clk);
      if (int_start !== 1'b0) extra_start = 1'b1;
    end
    n_total++; if (extra_start) $display("FAIL nmi_present_merge: got a second NMI presentation want none"); else n_pass++;
  endtask

  task automatic test_stalled_core();
    pres_t e;
    bit ok;
    int cyc;
    int inta_before;
    bit unstable = 1'b0;
    intr = 1'b1; irq = 8'h55;
    sb_q.push_back('{vector: 8'h55, nmi: 1'b0});
    wait_for_inta(3, ok, cyc);
    wait_for_start(4, ok, cyc);
    pop_expected(e);
    n_total++; if (!ok || int_vector !== e.vector) $display("FAIL stall_vector: got ok=%0b %h want %h", ok, int_vector, e.vector); else n_pass++;
    inta_before = inta_cnt;
    for (int i = 0; i < 50; i++) begin
      irq = 8'($urandom);
      @(negedge clk);
      if (int_vector !== e.vector || int_start !== 1'b1) unstable = 1'b1;
    end
    n_total++; if (unstable) $display("FAIL stall_hold: got vector/start change want constant %h/1", e.vector); else n_pass++;
    n_total++; if (inta_cnt != inta_before) $display("FAIL stall_no_inta: got %0d pulses want 0", inta_cnt - inta_before); else n_pass++;
    intr = 1'b0; irq = 8'h00;
    take_and_settle();
  endtask

  task automatic test_reset_mid_inta();
    pres_t e;
    bit ok;
    int cyc;
    bit start_seen = 1'b0;
    // A pending NMI is discarded by reset.
    inst_boundary = 1'b0; nmi = 1'b1;
    @(negedge clk);
    #2 reset_n = 1'b0; nmi = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; inst_boundary = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (int_start !== 1'b0) start_seen = 1'b1;
    end
    n_total++; if (start_seen) $display("FAIL reset_nmi_lost: got NMI presentation want none"); else n_pass++;

    intr = 1'b1; irq = 8'h66; int_enabled = 1'b1;
    @(negedge clk);
    n_total++; if (inta !== 1'b1) $display("FAIL reset_pre_inta: got %b want 1", inta); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_total++; if (inta !== 1'b0 || int_start !== 1'b0 || int_vector !== 8'h00 || int_nmi !== 1'b0)
      $display("FAIL reset_async_clear: got inta=%b start=%b vec=%h nmi=%b want 0/0/00/0", inta, int_start, int_vector, int_nmi);
    else n_pass++;
    intr = 1'b0; irq = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    intr = 1'b1; irq = 8'h77;
    sb_q.push_back('{vector: 8'h77, nmi: 1'b0});
    wait_for_inta(2, ok, cyc);
    n_total++; if (!ok || cyc != 1) $display("FAIL reset_fresh_inta: got ok=%0b cycles=%0d want 1", ok, cyc); else n_pass++;
    intr = 1'b0; irq = 8'h00;
    wait_for_start(4, ok, cyc);
    pop_expected(e);
    n_total++; if (!ok || int_vector !== e.vector || int_nmi !== e.nmi) $display("FAIL reset_fresh_vector: got ok=%0b %h/%b want %h/%b", ok, int_vector, int_nmi, e.vector, e.nmi); else n_pass++;
    take_and_settle();
  endtask

  task automatic test_invariants();
    n_total++; if (inta_consec) $display("FAIL inta_width: got inta high 2 consecutive cycles want 1"); else n_pass++;
    n_total++; if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_maskable();
    test_gating();
    test_nmi_priority();
    test_nmi_during_present();
    test_stalled_core();
    test_reset_mid_inta();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
